// File: rtl/snn_pkg.sv
// snn_pkg
// Shared definitions for the spike readout logic.
//   state_e          : classifier FSM states (IDLE / COUNT / SCAN / HOLD)
//   DEF_COUNTER_SIZE : default width of a per-lane spike count
//   DEF_WINDOW_WIDTH : default width of the window-length input
//   sat_inc()        : increment that sticks at a caller-supplied maximum
package snn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_SCAN  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam int DEF_COUNTER_SIZE = 8;
    localparam int DEF_WINDOW_WIDTH = 16;

    // Values are carried in 32 bits so one function serves any counter width
    // up to 31 bits; the caller truncates the result back to its own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                            input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/spike_sat_counter.sv
// spike_sat_counter
// One per-lane spike counter that saturates at all-ones instead of wrapping.
// Ports:
//   clk   in  rising-edge clock
//   rst_n in  synchronous active-low reset (count -> 0)
//   clr   in  synchronous clear (count -> 0), wins over counting
//   en    in  counting window is open
//   spike in  spike bit for this lane in the current cycle
//   count out registered spike count, COUNTER_SIZE bits
module spike_sat_counter
    import snn_pkg::*;
#(
    parameter int COUNTER_SIZE = DEF_COUNTER_SIZE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    spike,
    output logic [COUNTER_SIZE-1:0] count
);

    localparam logic [31:0] MAX_V = 32'((64'd1 << COUNTER_SIZE) - 64'd1);

    logic [COUNTER_SIZE-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count_q <= '0;
        end else if (en && spike) begin
            count_q <= COUNTER_SIZE'(sat_inc(32'(count_q), MAX_V));
        end
    end

    assign count = count_q;

endmodule

// File: rtl/spike_window_classifier.sv
// spike_window_classifier
// Counts spikes per lane over a programmable window of timesteps, then scans
// the counts one lane per cycle to find the most active lane. The result is
// held until the consumer takes it through a valid/ready handshake.
// Ports:
//   clk, rst_n    clock and synchronous active-low reset
//   start         begin a window (only honoured in IDLE)
//   abort         abandon any window in progress, back to IDLE
//   window_len    timesteps to count, latched on accepted start (0 acts as 1)
//   spike_in      one spike bit per lane per cycle
//   busy          high in COUNT, SCAN and HOLD
//   result_valid  result held (HOLD)
//   result_ready  consumer accepts the result
//   counts        lane i at [i*COUNTER_SIZE +: COUNTER_SIZE]
//   winner        index of the highest count (lowest index on ties)
//   no_spike      every count was zero (winner is then 0)
module spike_window_classifier
    import snn_pkg::*;
#(
    parameter int NUM_INPUTS   = 4,
    parameter int COUNTER_SIZE = DEF_COUNTER_SIZE,
    parameter int WINDOW_WIDTH = DEF_WINDOW_WIDTH,
    parameter int WINNER_WIDTH = (NUM_INPUTS > 2) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             abort,
    input  logic [WINDOW_WIDTH-1:0]          window_len,
    input  logic [NUM_INPUTS-1:0]            spike_in,
    output logic                             busy,
    output logic                             result_valid,
    input  logic                             result_ready,
    output logic [NUM_INPUTS*COUNTER_SIZE-1:0] counts,
    output logic [WINNER_WIDTH-1:0]          winner,
    output logic                             no_spike
);

    state_e state_q, state_d;

    logic [WINDOW_WIDTH-1:0] len_q;
    logic [WINDOW_WIDTH-1:0] tcnt_q;
    logic [WINNER_WIDTH-1:0] scan_idx_q;
    logic [COUNTER_SIZE-1:0] max_q;
    logic [WINNER_WIDTH-1:0] winner_q;
    logic                    no_spike_q;

    logic [COUNTER_SIZE-1:0] lane_cnt [NUM_INPUTS];

    logic start_ok;
    logic cnt_clr;
    logic cnt_en;
    logic count_done;
    logic scan_last;
    logic scan_gt;
    logic [COUNTER_SIZE-1:0] scan_cnt;

    assign start_ok   = (state_q == ST_IDLE) && start;
    assign cnt_clr    = abort || start_ok;
    assign cnt_en     = (state_q == ST_COUNT);
    // len_q is never 0 once latched, so len_q-1 is the index of the last timestep.
    assign count_done = (tcnt_q == len_q - WINDOW_WIDTH'(1));
    assign scan_last  = (scan_idx_q == WINNER_WIDTH'(NUM_INPUTS - 1));
    assign scan_cnt   = lane_cnt[scan_idx_q];
    // Strictly greater: an equal count later in the scan never displaces the
    // earlier lane, which gives lowest-index tie resolution.
    assign scan_gt    = (scan_cnt > max_q);

    // Per-lane saturating counters
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
        spike_sat_counter #(
            .COUNTER_SIZE (COUNTER_SIZE)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (cnt_clr),
            .en    (cnt_en),
            .spike (spike_in[i]),
            .count (lane_cnt[i])
        );
        assign counts[i*COUNTER_SIZE +: COUNTER_SIZE] = lane_cnt[i];
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort outranks both start and the handshake
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start)        state_d = ST_COUNT;
                ST_COUNT: if (count_done)   state_d = ST_SCAN;
                ST_SCAN:  if (scan_last)    state_d = ST_HOLD;
                ST_HOLD:  if (result_ready) state_d = ST_IDLE;
                default:                    state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy         = (state_q != ST_IDLE);
        result_valid = (state_q == ST_HOLD);
    end

    // Timestep counter and sequential argmax
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q      <= '0;
            tcnt_q     <= '0;
            scan_idx_q <= '0;
            max_q      <= '0;
            winner_q   <= '0;
            no_spike_q <= 1'b0;
        end else if (abort) begin
            tcnt_q     <= '0;
            scan_idx_q <= '0;
            max_q      <= '0;
            winner_q   <= '0;
            no_spike_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        len_q      <= (window_len == '0) ? WINDOW_WIDTH'(1) : window_len;
                        tcnt_q     <= '0;
                        scan_idx_q <= '0;
                        max_q      <= '0;
                        winner_q   <= '0;
                        no_spike_q <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    tcnt_q <= tcnt_q + WINDOW_WIDTH'(1);
                end
                ST_SCAN: begin
                    if (scan_gt) begin
                        max_q    <= scan_cnt;
                        winner_q <= scan_idx_q;
                    end
                    if (scan_last) begin
                        scan_idx_q <= '0;
                        // Final max is zero only if it was zero and this lane did not beat it.
                        no_spike_q <= !scan_gt && (max_q == '0);
                    end else begin
                        scan_idx_q <= scan_idx_q + WINNER_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign winner   = winner_q;
    assign no_spike = no_spike_q;

endmodule

// File: tb/tb_spike_window_classifier.sv
module tb_spike_window_classifier;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] window_len;
    logic [3:0]  spike_in;
    logic        busy;
    logic        result_valid;
    logic        result_ready;
    logic [15:0] counts;
    logic [1:0]  winner;
    logic        no_spike;

    int checks;
    int failures;

    spike_window_classifier #(
        .NUM_INPUTS   (4),
        .COUNTER_SIZE (4),
        .WINDOW_WIDTH (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .window_len   (window_len),
        .spike_in     (spike_in),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .counts       (counts),
        .winner       (winner),
        .no_spike     (no_spike)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one cycle; on return the DUT is in the first COUNT cycle.
    task automatic start_window(input int len);
        window_len = 16'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", result_valid); end
        checks++; if (counts !== 16'h0000) begin failures++; $display("FAIL reset_counts: got %h expected 0000", counts); end
        checks++; if (winner !== 2'd0) begin failures++; $display("FAIL reset_winner: got %0d expected 0", winner); end
        checks++; if (no_spike !== 1'b0) begin failures++; $display("FAIL reset_no_spike: got %0b expected 0", no_spike); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        start_window(10);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %0b expected 1", busy); end
        for (int k = 0; k < 10; k++) begin
            spike_in = 4'b0100 | (((k % 2) == 0) ? 4'b0001 : 4'b0000);
            tick();
        end
        spike_in = 4'b0000;
        repeat (3) tick();
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_early: got %0b expected 0 at T+14", result_valid); end
        tick();
        checks++; if (result_valid !== 1'b1) begin failures++; $display("FAIL basic_valid_latency: got %0b expected 1 at T+15", result_valid); end
        checks++; if (counts !== 16'h0A05) begin failures++; $display("FAIL basic_counts: got %h expected 0a05", counts); end
        checks++; if (winner !== 2'd2) begin failures++; $display("FAIL basic_winner: got %0d expected 2", winner); end
        checks++; if (no_spike !== 1'b0) begin failures++; $display("FAIL basic_no_spike: got %0b expected 0", no_spike); end
        handshake();
        checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_release: got valid=%0b busy=%0b expected 0 0", result_valid, busy); end
    endtask

    task automatic test_tie_and_silent();
        start_window(4);
        for (int k = 0; k < 4; k++) begin
            spike_in = 4'b1010;
            tick();
        end
        spike_in = 4'b0000;
        repeat (4) tick();
        checks++; if (result_valid !== 1'b1) begin failures++; $display("FAIL tie_valid: got %0b expected 1", result_valid); end
        checks++; if (counts !== 16'h4040) begin failures++; $display("FAIL tie_counts: got %h expected 4040", counts); end
        checks++; if (winner !== 2'd1) begin failures++; $display("FAIL tie_winner: got %0d expected 1", winner); end
        handshake();

        start_window(3);
        repeat (3) tick();
        repeat (4) tick();
        checks++; if (result_valid !== 1'b1) begin failures++; $display("FAIL silent_valid: got %0b expected 1", result_valid); end
        checks++; if (counts !== 16'h0000) begin failures++; $display("FAIL silent_counts: got %h expected 0000", counts); end
        checks++; if (no_spike !== 1'b1) begin failures++; $display("FAIL silent_no_spike: got %0b expected 1", no_spike); end
        checks++; if (winner !== 2'd0) begin failures++; $display("FAIL silent_winner: got %0d expected 0", winner); end
        handshake();
    endtask

    task automatic test_saturation();
        start_window(40);
        for (int k = 0; k < 40; k++) begin
            spike_in = 4'b0001;
            tick();
        end
        spike_in = 4'b0000;
        repeat (4) tick();
        checks++; if (result_valid !== 1'b1) begin failures++; $display("FAIL sat_valid: got %0b expected 1", result_valid); end
        checks++; if (counts !== 16'h000F) begin failures++; $display("FAIL sat_counts: got %h expected 000f", counts); end
        checks++; if (winner !== 2'd0 || no_spike !== 1'b0) begin failures++; $display("FAIL sat_winner: got winner=%0d no_spike=%0b expected 0 0", winner, no_spike); end
        handshake();

        // Zero length behaves as one timestep.
        start_window(0);
        spike_in = 4'b0010;
        tick();
        spike_in = 4'b0000;
        repeat (3) tick();
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL len0_valid_early: got %0b expected 0", result_valid); end
        tick();
        checks++; if (result_valid !== 1'b1) begin failures++; $display("FAIL len0_valid: got %0b expected 1", result_valid); end
        checks++; if (counts !== 16'h0010) begin failures++; $display("FAIL len0_counts: got %h expected 0010", counts); end
        checks++; if (winner !== 2'd1) begin failures++; $display("FAIL len0_winner: got %0d expected 1", winner); end
        handshake();
    endtask

    task automatic test_backpressure();
        start_window(3);
        for (int k = 0; k < 3; k++) begin
            spike_in = 4'b1000;
            tick();
        end
        spike_in = 4'b0000;
        repeat (4) tick();
        checks++; if (result_valid !== 1'b1 || counts !== 16'h3000 || winner !== 2'd3) begin failures++; $display("FAIL bp_result: got valid=%0b counts=%h winner=%0d expected 1 3000 3", result_valid, counts, winner); end
        result_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            start = 1'b1;
            window_len = 16'd7;
            spike_in = 4'b1111;
            tick();
            checks++;
            if ({result_valid, busy, counts, winner, no_spike} !== {1'b1, 1'b1, 16'h3000, 2'd3, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold_%0d: got valid=%0b busy=%0b counts=%h winner=%0d no_spike=%0b expected 1 1 3000 3 0",
                         k, result_valid, busy, counts, winner, no_spike);
            end
        end
        spike_in = 4'b0000;
        // Handshake cycle with start also high: start must be ignored.
        window_len = 16'd9;
        start = 1'b1;
        result_ready = 1'b1;
        tick();
        start = 1'b0;
        result_ready = 1'b0;
        checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_release: got valid=%0b busy=%0b expected 0 0", result_valid, busy); end
        start_window(2);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_restart_busy: got %0b expected 1", busy); end
        for (int k = 0; k < 2; k++) begin
            spike_in = 4'b0001;
            tick();
        end
        spike_in = 4'b0000;
        repeat (4) tick();
        checks++; if (result_valid !== 1'b1 || counts !== 16'h0002 || winner !== 2'd0) begin failures++; $display("FAIL bp_restart_result: got valid=%0b counts=%h winner=%0d expected 1 0002 0", result_valid, counts, winner); end
        handshake();
    endtask

    task automatic test_abort();
        start_window(10);
        for (int k = 0; k < 3; k++) begin
            spike_in = 4'b1111;
            tick();
        end
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        spike_in = 4'b0000;
        checks++; if (busy !== 1'b0 || result_valid !== 1'b0) begin failures++; $display("FAIL abort_count_state: got busy=%0b valid=%0b expected 0 0", busy, result_valid); end
        checks++; if (counts !== 16'h0000) begin failures++; $display("FAIL abort_count_counts: got %h expected 0000", counts); end
        repeat (20) tick();
        checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort_no_result: got valid=%0b busy=%0b expected 0 0", result_valid, busy); end

        start_window(1);
        spike_in = 4'b0100;
        tick();
        spike_in = 4'b0000;
        repeat (4) tick();
        checks++; if (result_valid !== 1'b1 || counts !== 16'h0100) begin failures++; $display("FAIL abort_hold_pre: got valid=%0b counts=%h expected 1 0100", result_valid, counts); end
        abort = 1'b1;
        result_ready = 1'b1;
        tick();
        abort = 1'b0;
        result_ready = 1'b0;
        checks++; if (result_valid !== 1'b0 || counts !== 16'h0000 || winner !== 2'd0) begin failures++; $display("FAIL abort_hold: got valid=%0b counts=%h winner=%0d expected 0 0000 0", result_valid, counts, winner); end
    endtask

    task automatic test_reset_mid();
        start_window(2);
        for (int k = 0; k < 2; k++) begin
            spike_in = 4'b0010;
            tick();
        end
        spike_in = 4'b0000;
        repeat (4) tick();
        checks++; if (result_valid !== 1'b1 || winner !== 2'd1) begin failures++; $display("FAIL rstmid_pre: got valid=%0b winner=%0d expected 1 1", result_valid, winner); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({busy, result_valid, counts, winner, no_spike} !== {1'b0, 1'b0, 16'h0000, 2'd0, 1'b0}) begin
            failures++;
            $display("FAIL rstmid_outputs: got busy=%0b valid=%0b counts=%h winner=%0d no_spike=%0b expected 0 0 0000 0 0",
                     busy, result_valid, counts, winner, no_spike);
        end
        start_window(5);
        for (int k = 0; k < 5; k++) begin
            spike_in = 4'b1000 | ((k < 2) ? 4'b0100 : 4'b0000);
            tick();
        end
        spike_in = 4'b0000;
        repeat (3) tick();
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL after_rst_valid_early: got %0b expected 0", result_valid); end
        tick();
        checks++; if (result_valid !== 1'b1) begin failures++; $display("FAIL after_rst_valid: got %0b expected 1", result_valid); end
        checks++; if (counts !== 16'h5200) begin failures++; $display("FAIL after_rst_counts: got %h expected 5200", counts); end
        checks++; if (winner !== 2'd3 || no_spike !== 1'b0) begin failures++; $display("FAIL after_rst_winner: got winner=%0d no_spike=%0b expected 3 0", winner, no_spike); end
        handshake();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL after_rst_idle: got busy=%0b expected 0", busy); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        window_len = 16'd0;
        spike_in = 4'b0000;
        result_ready = 1'b0;

        test_reset();
        test_basic();
        test_tie_and_silent();
        test_saturation();
        test_backpressure();
        test_abort();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
